// File: rtl/uart_frame_assembler.sv
// Assembles SYNC/opcode/A/B/checksum UART byte frames into one 66-bit frame word.
// Latency: frame_valid rises 1 clk after the checksum byte strobe; errors pulse 1 clk after the cause.
// Backpressure: a checked frame is held until frame_ready; bytes arriving meanwhile are dropped with overrun.
module uart_frame_assembler #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        frame_ready,
    output logic [65:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        overrun,
    output logic        busy
);
    localparam logic [19:0] IDLE_LIMIT = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {HUNT, OPC, DATA, CHK, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  opcode;
    logic [63:0] staging;
    logic [2:0]  byte_cnt;
    logic [7:0]  xor_acc;
    logic [19:0] idle_cnt;
    logic        in_frame;
    logic        timeout;
    logic        abort;
    logic        load_frame;
    logic [1:0]  abort_code;

    assign in_frame = (state == OPC) || (state == DATA) || (state == CHK);
    // A byte landing on the would-be timeout cycle wins over the timeout.
    assign timeout  = in_frame && !rx_valid && (idle_cnt == IDLE_LIMIT);
    assign busy     = (state != HUNT);

    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        abort_code = 2'b00;
        load_frame = 1'b0;
        case (state)
            HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_nxt = OPC;
            end
            OPC: begin
                if (rx_valid) begin
                    if (rx_data[7:2] == 6'd0) begin
                        state_nxt = DATA;
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'b01;
                    end
                end else if (timeout) begin
                    abort      = 1'b1;
                    abort_code = 2'b11;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (byte_cnt == 3'd7) state_nxt = CHK;
                end else if (timeout) begin
                    abort      = 1'b1;
                    abort_code = 2'b11;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == xor_acc) begin
                        load_frame = 1'b1;
                        state_nxt  = HOLD;
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'b10;
                    end
                end else if (timeout) begin
                    abort      = 1'b1;
                    abort_code = 2'b11;
                end
            end
            HOLD: begin
                if (frame_ready) state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
        if (abort) state_nxt = HUNT;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'b00;
            overrun     <= 1'b0;
            opcode      <= 2'b00;
            staging     <= '0;
            byte_cnt    <= 3'd0;
            xor_acc     <= 8'd0;
            idle_cnt    <= 20'd0;
        end else begin
            frame_err <= abort;
            overrun   <= (state == HOLD) && rx_valid;
            if (abort) err_code <= abort_code;

            if (load_frame) begin
                frame_data  <= {opcode, staging};
                frame_valid <= 1'b1;
            end else if (state == HOLD && frame_ready) begin
                frame_valid <= 1'b0;
            end

            // Per-frame accumulators are zero whenever no frame is being collected.
            if (!in_frame || abort || load_frame) begin
                byte_cnt <= 3'd0;
                xor_acc  <= 8'd0;
                idle_cnt <= 20'd0;
            end else if (rx_valid) begin
                idle_cnt <= 20'd0;
                xor_acc  <= xor_acc ^ rx_data;
                if (state == OPC) opcode <= rx_data[1:0];
                if (state == DATA) begin
                    staging  <= {staging[55:0], rx_data};
                    byte_cnt <= byte_cnt + 3'd1;
                end
            end else begin
                idle_cnt <= idle_cnt + 20'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomised and directed bench for uart_frame_assembler against a byte-position frame model.
module tb_uart_frame_assembler;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        frame_ready = 1'b0;
    logic [65:0] frame_data;
    logic        frame_valid;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        overrun;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_frame_assembler #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_ready(frame_ready), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_err(frame_err), .err_code(err_code), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: position within the wire frame (0 = hunting), bytes so far, idle gap.
    logic [7:0]  fb [0:10];
    int          got = 0;
    int          gap = 0;
    bit          holding = 1'b0;
    bit          started = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_ovr = 1'b0;
    logic [1:0]  m_code = 2'b00;
    logic [65:0] m_data = '0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_abort(input logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        got    = 0;
        gap    = 0;
    endtask

    task automatic model_step();
        logic [7:0] x;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (reset) begin
            got = 0; gap = 0; holding = 1'b0;
            m_valid = 1'b0; m_code = 2'b00; m_data = '0;
        end else if (holding) begin
            if (rx_valid) m_ovr = 1'b1;
            if (frame_ready) begin
                holding = 1'b0;
                m_valid = 1'b0;
            end
        end else if (got == 0) begin
            if (rx_valid && rx_data == SYNC) got = 1;
            gap = 0;
        end else if (rx_valid) begin
            fb[got] = rx_data;
            gap = 0;
            if (got == 1 && rx_data > 8'd3) begin
                model_abort(2'b01);
            end else if (got == 10) begin
                x = 8'h00;
                for (int i = 1; i <= 9; i++) x ^= fb[i];
                if (x == rx_data) begin
                    m_data  = {fb[1][1:0], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7], fb[8], fb[9]};
                    m_valid = 1'b1;
                    holding = 1'b1;
                    got     = 0;
                end else begin
                    model_abort(2'b10);
                end
            end else begin
                got++;
            end
        end else begin
            gap++;
            if (gap == TMO) model_abort(2'b11);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("frame_valid", 66'(frame_valid), 66'(m_valid));
            chk("frame_err",   66'(frame_err),   66'(m_err));
            chk("err_code",    66'(err_code),    66'(m_code));
            chk("overrun",     66'(overrun),     66'(m_ovr));
            chk("busy",        66'(busy),        66'((got != 0) || holding));
            chk("frame_data",  frame_data,       m_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [7:0] cs);
        send(SYNC);
        send(op);
        for (int i = 3; i >= 0; i--) send(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send(b[8*i +: 8]);
        send(cs);
    endtask

    logic [65:0] good_word;
    logic [7:0]  q [$];
    int          hi;
    int          n;

    initial begin
        good_word = {2'b00, 32'h3F80_0000, 32'h4000_0000};
        repeat (3) tick();
        chk("reset_data", frame_data, 66'h0);
        chk("reset_busy", 66'(busy), 66'h0);
        reset = 1'b0;
        tick();

        // Good frame, downstream ready: one-cycle valid.
        frame_ready = 1'b1;
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000, 8'hFF);
        chk("good_valid", 66'(frame_valid), 66'h1);
        chk("good_data", frame_data, good_word);
        tick();
        chk("good_valid_drop", 66'(frame_valid), 66'h0);

        // Backpressure with an overrun byte in the middle of the hold.
        frame_ready = 1'b0;
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000, 8'hFF);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_valid) hi++;
            rx_valid = (i == 5);
            rx_data  = 8'h55;
            tick();
            rx_valid = 1'b0;
            if (i == 5) chk("hold_overrun", 66'(overrun), 66'h1);
        end
        frame_ready = 1'b1;
        if (frame_valid) hi++;
        tick();
        if (frame_valid) hi++;
        chk("hold_cycles", 66'(hi), 66'd21);
        chk("hold_data", frame_data, good_word);

        // Checksum error leaves the previous frame in place.
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000, 8'hFE);
        chk("cs_err", 66'(frame_err), 66'h1);
        chk("cs_code", 66'(err_code), 66'h2);
        chk("cs_novalid", 66'(frame_valid), 66'h0);
        chk("cs_data", frame_data, good_word);

        // Hunt discards junk, bad opcode aborts, then opcode 2 frame.
        send(8'h00); send(8'h13); send(SYNC); send(8'h04);
        chk("op_err", 66'(frame_err), 66'h1);
        chk("op_code", 66'(err_code), 66'h1);
        send_frame(8'h02, 32'h3F80_0000, 32'h3F80_0000, 8'h02);
        chk("op2_data", frame_data, {2'b10, 32'h3F80_0000, 32'h3F80_0000});

        // Timeout exactly TMO cycles after the last byte.
        tick();
        send(SYNC); send(8'h01); send(8'h3F);
        n = 0;
        while (!frame_err && n < 3 * TMO) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 66'(n), 66'(TMO));
        chk("tmo_code", 66'(err_code), 66'h3);
        tick();
        chk("tmo_pulse", 66'(frame_err), 66'h0);

        // A byte on the timeout cycle keeps the frame alive.
        send(SYNC); send(8'h01); send(8'h3F);
        repeat (TMO - 1) tick();
        send(8'h80);
        chk("tmo_saved", 66'(frame_err), 66'h0);
        chk("tmo_busy", 66'(busy), 66'h1);
        send(8'h00); send(8'h00);
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        send(8'hFE);
        chk("tmo_frame", frame_data, {2'b01, 32'h3F80_0000, 32'h4000_0000});
        tick();

        // Reset mid-frame.
        send(SYNC); send(8'h00); send(8'h3F); send(8'h80); send(8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 66'(busy), 66'h0);
        chk("rst_err", 66'(frame_err), 66'h0);
        chk("rst_data", frame_data, 66'h0);
        send_frame(8'h00, 32'h3F80_0000, 32'h4000_0000, 8'hFF);
        chk("rst_good", frame_data, good_word);

        // Random traffic: good, corrupt, bad opcode and noise bytes with random gaps and ready.
        for (int f = 0; f < 120; f++) begin
            int          kind;
            logic [7:0]  cs;
            logic [7:0]  b;
            q.delete();
            kind = $urandom_range(0, 5);
            if (kind == 5) begin
                for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom));
            end else begin
                q.push_back(SYNC);
                b = (kind == 4) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
                q.push_back(b);
                cs = b;
                for (int i = 0; i < 8; i++) begin
                    b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
                    q.push_back(b);
                    cs ^= b;
                end
                if (kind == 3) cs ^= 8'(1 << $urandom_range(0, 7));
                q.push_back(cs);
            end
            foreach (q[i]) begin
                int g;
                g = ($urandom_range(0, 60) == 0) ? $urandom_range(TMO - 3, TMO + 3)
                                                 : $urandom_range(0, 3);
                repeat (g) begin
                    frame_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                frame_ready = ($urandom_range(0, 3) != 0);
                send(q[i]);
            end
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        frame_ready = 1'b1;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
